// File: rtl/tdm_cal_loader.sv
// tdm_cal_loader: write side of the Rx TDM calendar.
// Software writes a shadow calendar and end pointer through the config port.
// A commit copies shadow to active only on a walker wrap, so the active table
// never changes in the middle of a walk. The FSM state is visible on commitPending.
//
// Handshake: all config inputs are single-cycle qualifiers (cfgWrEn, cfgEndWrEn,
// cfgCommit, cfgRdEn) sampled on the rising edge. There is no backpressure.
// cfgRdVld, commitDone and cfgErr are single-cycle pulses one cycle after the
// qualifying edge.
module tdm_cal_loader #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 96,
  parameter int AW    = 7
) (
  input  logic                   clockCore,
  input  logic                   resetCore,
  input  logic                   cfgWrEn,
  input  logic [AW-1:0]          cfgAddr,
  input  logic [WIDTH-1:0]       cfgWrData,
  input  logic                   cfgEndWrEn,
  input  logic [AW-1:0]          cfgEndPtr,
  input  logic                   cfgCommit,
  input  logic                   cfgRdEn,
  input  logic [AW-1:0]          cfgRdAddr,
  output logic [WIDTH-1:0]       cfgRdData,
  output logic                   cfgRdVld,
  input  logic                   walkWrap,
  output logic [DEPTH*WIDTH-1:0] calEntryBus,
  output logic [AW-1:0]          walkEndPtr,
  output logic                   commitPending,
  output logic                   commitDone,
  output logic                   cfgErr
);

  localparam logic [AW-1:0]    LAST_IDX  = AW'(DEPTH - 1);
  localparam logic [WIDTH-1:0] ENTRY_RST = '1;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] shadow [DEPTH];
  logic [AW-1:0]    shadow_end;

  logic in_idle;
  logic wr_in_range;
  logic end_in_range;
  logic rd_in_range;
  logic wr_ok;
  logic end_ok;
  logic bad_access;
  logic copy_en;

  // Access qualification: shadow is writable only in IDLE and only in range.
  always_comb begin
    in_idle      = (state_q == IDLE);
    wr_in_range  = (cfgAddr <= LAST_IDX);
    end_in_range = (cfgEndPtr <= LAST_IDX);
    rd_in_range  = (cfgRdAddr <= LAST_IDX);
    wr_ok        = cfgWrEn && in_idle && wr_in_range;
    end_ok       = cfgEndWrEn && in_idle && end_in_range;
    // One error pulse per offending cycle, however many accesses were bad.
    bad_access   = (cfgWrEn && !(in_idle && wr_in_range)) ||
                   (cfgEndWrEn && !(in_idle && end_in_range)) ||
                   (cfgRdEn && !rd_in_range);
    // A wrap in the same cycle as the commit request does not copy.
    copy_en      = (state_q == PEND) && walkWrap;
  end

  // Next-state logic: commit arms the FSM, the next walker wrap completes it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cfgCommit) state_d = PEND;
      PEND:    if (walkWrap)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any pending commit.
  always_ff @(posedge clockCore) begin
    if (resetCore) state_q <= IDLE;
    else           state_q <= state_d;
  end

  assign commitPending = (state_q == PEND);

  // Shadow table and shadow end pointer, written by software while IDLE.
  always_ff @(posedge clockCore) begin
    if (resetCore) begin
      for (int i = 0; i < DEPTH; i++) shadow[i] <= ENTRY_RST;
      shadow_end <= LAST_IDX;
    end else begin
      if (wr_ok)  shadow[cfgAddr] <= cfgWrData;
      if (end_ok) shadow_end      <= cfgEndPtr;
    end
  end

  // Active table: loads from shadow only on the wrap edge of a pending commit.
  always_ff @(posedge clockCore) begin
    if (resetCore) begin
      calEntryBus <= '1;
      walkEndPtr  <= LAST_IDX;
    end else if (copy_en) begin
      for (int i = 0; i < DEPTH; i++) calEntryBus[i*WIDTH +: WIDTH] <= shadow[i];
      walkEndPtr <= shadow_end;
    end
  end

  // Shadow readback with one cycle of latency; out-of-range reads return zero.
  always_ff @(posedge clockCore) begin
    if (resetCore) begin
      cfgRdData <= '0;
      cfgRdVld  <= 1'b0;
    end else begin
      cfgRdVld <= cfgRdEn;
      if (cfgRdEn) cfgRdData <= rd_in_range ? shadow[cfgRdAddr] : '0;
    end
  end

  // Status pulses: commit completion and rejected accesses.
  always_ff @(posedge clockCore) begin
    if (resetCore) begin
      commitDone <= 1'b0;
      cfgErr     <= 1'b0;
    end else begin
      commitDone <= copy_en;
      cfgErr     <= bad_access;
    end
  end

endmodule

// File: tb/tb_tdm_cal_loader.sv
// Directed testbench for tdm_cal_loader. Expected tables are kept in a small
// shadow/active model updated by hand alongside each stimulus step.
module tb_tdm_cal_loader;

  localparam int WIDTH = 5;
  localparam int DEPTH = 96;
  localparam int AW    = 7;
  localparam int BW    = DEPTH * WIDTH;

  // ---------------- clock / reset ----------------
  logic clockCore = 1'b0;
  logic resetCore = 1'b1;
  always #5 clockCore = ~clockCore;

  logic             cfgWrEn = 1'b0;
  logic [AW-1:0]    cfgAddr = '0;
  logic [WIDTH-1:0] cfgWrData = '0;
  logic             cfgEndWrEn = 1'b0;
  logic [AW-1:0]    cfgEndPtr = '0;
  logic             cfgCommit = 1'b0;
  logic             cfgRdEn = 1'b0;
  logic [AW-1:0]    cfgRdAddr = '0;
  logic [WIDTH-1:0] cfgRdData;
  logic             cfgRdVld;
  logic             walkWrap = 1'b0;
  logic [BW-1:0]    calEntryBus;
  logic [AW-1:0]    walkEndPtr;
  logic             commitPending;
  logic             commitDone;
  logic             cfgErr;

  tdm_cal_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clockCore     (clockCore),
    .resetCore     (resetCore),
    .cfgWrEn       (cfgWrEn),
    .cfgAddr       (cfgAddr),
    .cfgWrData     (cfgWrData),
    .cfgEndWrEn    (cfgEndWrEn),
    .cfgEndPtr     (cfgEndPtr),
    .cfgCommit     (cfgCommit),
    .cfgRdEn       (cfgRdEn),
    .cfgRdAddr     (cfgRdAddr),
    .cfgRdData     (cfgRdData),
    .cfgRdVld      (cfgRdVld),
    .walkWrap      (walkWrap),
    .calEntryBus   (calEntryBus),
    .walkEndPtr    (walkEndPtr),
    .commitPending (commitPending),
    .commitDone    (commitDone),
    .cfgErr        (cfgErr)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_sh  [DEPTH];
  logic [WIDTH-1:0] exp_act [DEPTH];
  logic [AW-1:0]    exp_end_sh;
  logic [AW-1:0]    exp_end_act;

  task automatic check_eq(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] pack_act();
    logic [BW-1:0] b;
    for (int i = 0; i < DEPTH; i++) b[i*WIDTH +: WIDTH] = exp_act[i];
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      exp_sh[i]  = 5'h1F;
      exp_act[i] = 5'h1F;
    end
    exp_end_sh  = 7'd95;
    exp_end_act = 7'd95;
  endtask

  task automatic model_copy();
    for (int i = 0; i < DEPTH; i++) exp_act[i] = exp_sh[i];
    exp_end_act = exp_end_sh;
  endtask

  // ---------------- driver tasks ----------------
  // One clock edge; outputs are sampled 1ns later and pulse inputs are cleared.
  task automatic tick();
    @(posedge clockCore);
    #1;
    cfgWrEn    = 1'b0;
    cfgEndWrEn = 1'b0;
    cfgCommit  = 1'b0;
    cfgRdEn    = 1'b0;
    walkWrap   = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input logic pend, input logic done, input logic err);
    check_eq({tag, "/bus"},  calEntryBus, pack_act());
    check_eq({tag, "/end"},  BW'(walkEndPtr), BW'(exp_end_act));
    check_eq({tag, "/pend"}, BW'(commitPending), BW'(pend));
    check_eq({tag, "/done"}, BW'(commitDone), BW'(done));
    check_eq({tag, "/err"},  BW'(cfgErr), BW'(err));
  endtask

  task automatic do_read(input string tag, input logic [AW-1:0] addr,
                         input logic [WIDTH-1:0] exp, input logic err_exp);
    cfgRdEn   = 1'b1;
    cfgRdAddr = addr;
    exp_q.push_back(exp);
    tick();
    check_eq({tag, "/rdvld"}, BW'(cfgRdVld), BW'(1'b1));
    check_eq({tag, "/rddata"}, BW'(cfgRdData), BW'(exp_q.pop_front()));
    check_eq({tag, "/rderr"}, BW'(cfgErr), BW'(err_exp));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    tick();
    tick();
    resetCore = 1'b0;
    check_outputs("reset", 1'b0, 1'b0, 1'b0);
    check_eq("reset/entry0", BW'(calEntryBus[0 +: WIDTH]), BW'(5'h1F));
    check_eq("reset/rdvld", BW'(cfgRdVld), BW'(1'b0));
    check_eq("reset/rddata", BW'(cfgRdData), BW'(5'h00));

    // Basic commit: program two entries and end pointer, wrap ten cycles later.
    cfgWrEn = 1'b1; cfgAddr = 7'd0; cfgWrData = 5'd3; tick(); exp_sh[0] = 5'd3;
    cfgWrEn = 1'b1; cfgAddr = 7'd1; cfgWrData = 5'd7; tick(); exp_sh[1] = 5'd7;
    cfgEndWrEn = 1'b1; cfgEndPtr = 7'd1; tick(); exp_end_sh = 7'd1;
    check_outputs("pre_commit", 1'b0, 1'b0, 1'b0);
    cfgCommit = 1'b1; tick();
    check_outputs("commit", 1'b1, 1'b0, 1'b0);
    for (int k = 1; k < 10; k++) begin
      tick();
      check_outputs($sformatf("wait%0d", k), 1'b1, 1'b0, 1'b0);
    end
    walkWrap = 1'b1; tick(); model_copy();
    check_outputs("wrap", 1'b0, 1'b1, 1'b0);
    check_eq("wrap/entry0", BW'(calEntryBus[0 +: WIDTH]), BW'(5'd3));
    check_eq("wrap/entry1", BW'(calEntryBus[WIDTH +: WIDTH]), BW'(5'd7));
    check_eq("wrap/endptr", BW'(walkEndPtr), BW'(7'd1));
    tick();
    check_outputs("after_wrap", 1'b0, 1'b0, 1'b0);
    do_read("rd1", 7'd1, 5'd7, 1'b0);

    // Commit and wrap in the same IDLE cycle: copy waits for the next wrap.
    cfgWrEn = 1'b1; cfgAddr = 7'd2; cfgWrData = 5'd12; tick(); exp_sh[2] = 5'd12;
    cfgCommit = 1'b1; walkWrap = 1'b1; tick();
    check_outputs("collide", 1'b1, 1'b0, 1'b0);
    tick();
    check_outputs("collide_hold", 1'b1, 1'b0, 1'b0);
    walkWrap = 1'b1; tick(); model_copy();
    check_outputs("collide_wrap", 1'b0, 1'b1, 1'b0);
    check_eq("collide_wrap/entry2", BW'(calEntryBus[2*WIDTH +: WIDTH]), BW'(5'd12));

    // Write alongside commit is included; writes in PEND are rejected.
    cfgWrEn = 1'b1; cfgAddr = 7'd4; cfgWrData = 5'd17; cfgCommit = 1'b1; tick();
    exp_sh[4] = 5'd17;
    check_outputs("commit_wr", 1'b1, 1'b0, 1'b0);
    cfgWrEn = 1'b1; cfgAddr = 7'd5; cfgWrData = 5'd9; tick();
    check_outputs("frozen_wr", 1'b1, 1'b0, 1'b1);
    cfgEndWrEn = 1'b1; cfgEndPtr = 7'd3; tick();
    check_outputs("frozen_end", 1'b1, 1'b0, 1'b1);
    cfgCommit = 1'b1; tick();
    check_outputs("pend_commit", 1'b1, 1'b0, 1'b0);
    do_read("frozen_rd5", 7'd5, 5'h1F, 1'b0);
    walkWrap = 1'b1; tick(); model_copy();
    check_outputs("frozen_wrap", 1'b0, 1'b1, 1'b0);
    check_eq("frozen_wrap/entry5", BW'(calEntryBus[5*WIDTH +: WIDTH]), BW'(5'h1F));
    check_eq("frozen_wrap/entry4", BW'(calEntryBus[4*WIDTH +: WIDTH]), BW'(5'd17));
    tick();
    check_eq("single_done", BW'(commitDone), BW'(1'b0));

    // Range errors and boundaries.
    cfgWrEn = 1'b1; cfgAddr = 7'd96; cfgWrData = 5'd0; tick();
    check_outputs("wr96", 1'b0, 1'b0, 1'b1);
    tick();
    check_outputs("wr96_clear", 1'b0, 1'b0, 1'b0);
    cfgEndWrEn = 1'b1; cfgEndPtr = 7'd100; tick();
    check_outputs("end100", 1'b0, 1'b0, 1'b1);
    do_read("rd127", 7'd127, 5'd0, 1'b1);
    cfgWrEn = 1'b1; cfgAddr = 7'd3; cfgWrData = 5'd21;
    do_read("rd_wr_same", 7'd3, 5'h1F, 1'b0);
    exp_sh[3] = 5'd21;
    do_read("rd3_new", 7'd3, 5'd21, 1'b0);
    cfgWrEn = 1'b1; cfgAddr = 7'd95; cfgWrData = 5'd6;
    cfgEndWrEn = 1'b1; cfgEndPtr = 7'd95; tick();
    exp_sh[95] = 5'd6; exp_end_sh = 7'd95;
    check_outputs("edge95", 1'b0, 1'b0, 1'b0);
    cfgWrEn = 1'b1; cfgAddr = 7'd100; cfgWrData = 5'd2;
    do_read("bad_rd_wr", 7'd120, 5'd0, 1'b1);
    tick();
    check_outputs("bad_rd_wr_clear", 1'b0, 1'b0, 1'b0);
    cfgCommit = 1'b1; tick();
    walkWrap = 1'b1; tick(); model_copy();
    check_outputs("range_wrap", 1'b0, 1'b1, 1'b0);
    check_eq("range_wrap/entry95", BW'(calEntryBus[95*WIDTH +: WIDTH]), BW'(5'd6));
    check_eq("range_wrap/endptr", BW'(walkEndPtr), BW'(7'd95));

    // Reset in PEND drops the commit without commitDone.
    cfgWrEn = 1'b1; cfgAddr = 7'd0; cfgWrData = 5'd1; tick();
    cfgCommit = 1'b1; tick();
    check_eq("rst_pend/pend", BW'(commitPending), BW'(1'b1));
    resetCore = 1'b1; tick();
    resetCore = 1'b0; model_reset();
    check_outputs("rst_pend", 1'b0, 1'b0, 1'b0);
    tick();
    check_outputs("rst_pend_hold", 1'b0, 1'b0, 1'b0);
    walkWrap = 1'b1; tick();
    check_outputs("rst_wrap", 1'b0, 1'b0, 1'b0);
    tick();
    check_outputs("rst_wrap_after", 1'b0, 1'b0, 1'b0);
    do_read("rst_rd0", 7'd0, 5'h1F, 1'b0);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tdm_cal_loader.md
Name: tdm_cal_loader

Overview:
- Write side of the Rx TDM calendar.
- Holds a shadow copy of the calendar and walk end pointer, which software programs through a simple config port.
- Holds an active copy, driven flat to the calendar walker's calEntry/walkEndPtr inputs.
- A commit request is deferred until the walker signals a wrap, so the active table never changes mid-walk.

Parameters:
WIDTH, 5, channel-select width per calendar entry
DEPTH, 96, number of calendar entries (max 128)
AW, 7, entry address / end-pointer width

Ports:
clockCore  in  1  core clock, all logic on rising edge
resetCore  in  1  synchronous reset, active-high
cfgWrEn  in  1  write shadow entry cfgAddr with cfgWrData
cfgAddr  in  AW  shadow entry write address
cfgWrData  in  WIDTH  shadow entry write data
cfgEndWrEn  in  1  write shadow end pointer with cfgEndPtr
cfgEndPtr  in  AW  shadow end pointer value
cfgCommit  in  1  single-cycle pulse, request shadow->active copy
cfgRdEn  in  1  read shadow entry cfgRdAddr
cfgRdAddr  in  AW  shadow read address
cfgRdData  out  WIDTH  read data, valid with cfgRdVld
cfgRdVld  out  1  read data valid pulse
walkWrap  in  1  from walker: high in the cycle walkIdx==walkEndPtr
calEntryBus  out  DEPTH*WIDTH  active table; entry i at bits [i*WIDTH +: WIDTH]
walkEndPtr  out  AW  active end pointer
commitPending  out  1  commit accepted, waiting for wrap
commitDone  out  1  single-cycle pulse, active table updated
cfgErr  out  1  single-cycle pulse, rejected config access

Behaviour:
- Reset, synchronous on resetCore=1:
  - All shadow and active entries = {WIDTH{1'b1}}.
  - Shadow and active end pointer = DEPTH-1.
  - cfgRdData = 0; cfgRdVld, commitPending, commitDone and cfgErr = 0.
  - FSM = IDLE.
  - Reset mid-PEND drops the commit silently, with no commitDone.
- FSM has two states, IDLE and PEND. commitPending = (state==PEND), registered.
- IDLE:
  - cfgWrEn with cfgAddr<DEPTH writes shadow[cfgAddr] at the edge.
  - cfgWrEn with cfgAddr>=DEPTH is ignored, cfgErr=1 next cycle.
  - cfgEndWrEn with cfgEndPtr<=DEPTH-1 writes the shadow end pointer.
  - cfgEndWrEn with cfgEndPtr>DEPTH-1 is ignored, cfgErr=1 next cycle.
  - cfgCommit -> PEND.
  - A write in the same cycle as cfgCommit lands in shadow and is included in the commit.
  - walkWrap in the same cycle as cfgCommit does NOT copy; the copy waits for the next walkWrap.
- PEND:
  - Shadow is frozen: any cfgWrEn or cfgEndWrEn is ignored, cfgErr=1 next cycle.
  - cfgCommit is ignored; no error, no second commit.
  - On walkWrap=1, all active entries and the active end pointer load from shadow at that edge, and the FSM -> IDLE.
  - commitDone=1 in the cycle after the copy edge; its assertion coincides with commitPending returning to 0.
  - The walker's walkIdx returns to 0 on the same edge, so entry 0 of the next walk is read from the new table.
- Active outputs are registers. calEntryBus and walkEndPtr change only on a PEND+walkWrap edge or on reset.
- Reads:
  - Allowed in any state; cfgRdEn samples cfgRdAddr.
  - One-cycle latency: cfgRdVld=1 and cfgRdData = shadow[cfgRdAddr] next cycle.
  - Read of the same address as a same-cycle write returns the old value.
  - cfgRdAddr>=DEPTH returns cfgRdData=0 and also pulses cfgErr.
- cfgErr is a single pulse per offending cycle. Simultaneous bad read and bad write give one pulse.
- No arithmetic beyond address compares; all compares are unsigned AW-bit.

Test Plan:
- Reset check: after reset, every calEntryBus entry = 5'h1F, walkEndPtr=95, commitPending=0, commitDone=0.
- Basic commit:
  - Stimulus: write shadow[0]=3, [1]=7, end=1, pulse cfgCommit; walkWrap at cycle +10.
  - Required: commitPending=1 from commit+1 through the copy edge.
  - Required: calEntryBus[0]=3, [1]=7, walkEndPtr=1 after the wrap edge.
  - Required: commitDone pulses exactly once; active outputs unchanged before the wrap.
- Collision in IDLE: cfgCommit and walkWrap in the same cycle -> no copy at that edge; copy happens on the next walkWrap.
- Frozen shadow:
  - Stimulus: in PEND, cfgWrEn addr 5 data 9.
  - Required: cfgErr pulse; shadow[5] unchanged (readback); committed table has the old entry 5.
- Range errors:
  - Write addr 96 -> cfgErr pulse, no state change.
  - cfgEndPtr=100 -> cfgErr pulse, end pointer unchanged.
  - Read addr 127 -> cfgRdVld=1, cfgRdData=0, cfgErr pulse.
- Reset mid-PEND: commit, assert resetCore before walkWrap -> tables back to 5'h1F / end pointer 95, no commitDone, FSM IDLE (a later walkWrap causes no copy).
